// File: rtl/switch_reader.sv
// Debounced reader for eight slide switches and one pushbutton; each clean
// press captures the stable switch byte and pulses data_valid for one cycle.
module switch_reader #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk100mhz,
    input  logic       rst,
    input  logic [7:0] sw,
    input  logic       btn,
    output logic [7:0] sw_stable,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       btn_held,
    output logic [7:0] press_count
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    // Two-flop synchroniser; bit 8 carries the button.
    logic [8:0] sync1;
    logic [8:0] sync2;
    logic [7:0] sw_s;
    logic       btn_s;

    always_ff @(posedge clk100mhz) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {btn, sw};
            sync2 <= sync1;
        end
    end

    assign sw_s  = sync2[7:0];
    assign btn_s = sync2[8];

    // Switch filter: any difference from the candidate restarts the count.
    logic [7:0]    sw_cand;
    logic [CW-1:0] scnt;

    always_ff @(posedge clk100mhz) begin
        if (rst) begin
            sw_cand   <= '0;
            scnt      <= '0;
            sw_stable <= '0;
        end else if (sw_s != sw_cand) begin
            sw_cand <= sw_s;
            scnt    <= '0;
        end else if (scnt == CNT_LAST) begin
            sw_stable <= sw_cand;
        end else begin
            scnt <= scnt + CW'(1);
        end
    end

    // Button FSM
    state_t        state_q;
    state_t        state_n;
    logic [CW-1:0] bcnt_q;
    logic [CW-1:0] bcnt_n;
    logic          accept;

    always_comb begin
        state_n = state_q;
        bcnt_n  = bcnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_n = PRESS_WAIT;
                    bcnt_n  = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_n = IDLE;
                end else if (bcnt_q == CNT_LAST) begin
                    state_n = PRESSED;
                    accept  = 1'b1;
                end else begin
                    bcnt_n = bcnt_q + CW'(1);
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_n = RELEASE_WAIT;
                    bcnt_n  = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_n = PRESSED;
                end else if (bcnt_q == CNT_LAST) begin
                    state_n = IDLE;
                end else begin
                    bcnt_n = bcnt_q + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                bcnt_n  = '0;
            end
        endcase
    end

    // btn_held decodes the next state so it tracks the state register exactly.
    always_ff @(posedge clk100mhz) begin
        if (rst) begin
            state_q     <= IDLE;
            bcnt_q      <= '0;
            data_valid  <= 1'b0;
            data_out    <= '0;
            press_count <= '0;
            btn_held    <= 1'b0;
        end else begin
            state_q    <= state_n;
            bcnt_q     <= bcnt_n;
            data_valid <= accept;
            btn_held   <= (state_n == PRESSED) || (state_n == RELEASE_WAIT);
            if (accept) begin
                data_out    <= sw_stable;
                press_count <= press_count + 8'd1;
            end
        end
    end

endmodule
